// File: rtl/pll_reset_sequencer.sv
// Staged reset release for the PLL clock domain, with filtered lock-loss re-assertion.
// Optional saturating loss counter port enabled by macro PLL_RST_SEQ_LOSS_COUNT_EN.
module pll_reset_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned STAGES        = 3,
  parameter int unsigned STAGE_GAP     = 16,
  parameter int unsigned LOSS_FILTER   = 4
) (
  input  logic              clock_in,
  input  logic              rst_in,
  input  logic              pll_locked,
  input  logic              clear_in,
  output logic [STAGES-1:0] rst_out,
  output logic              ready,
`ifdef PLL_RST_SEQ_LOSS_COUNT_EN
  output logic              lock_lost,
  output logic [7:0]        loss_count
`else
  output logic              lock_lost
`endif
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned GW = $clog2(STAGE_GAP + 1);
  localparam int unsigned FW = $clog2(LOSS_FILTER + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(STAGE_GAP - 1);
  localparam logic [FW-1:0] FILT_LAST   = FW'(LOSS_FILTER - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [FW-1:0]     filt_q, filt_d;
  logic [STAGES-1:0] rst_q, rst_d;
  logic              ready_q, ready_d;
  logic              lost_q, lost_d;
  logic              loss_event;

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    gap_d      = gap_q;
    filt_d     = filt_q;
    rst_d      = rst_q;
    ready_d    = ready_q;
    lost_d     = clear_in ? 1'b0 : lost_q;
    loss_event = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        rst_d   = '1;
        ready_d = 1'b0;
        filt_d  = '0;
        if (pll_locked) begin
          state_d  = SETTLE;
          settle_d = '0;
        end
      end
      SETTLE: begin
        if (!pll_locked) begin
          state_d = WAIT_LOCK;
        end else begin
          settle_d = settle_q + SW'(1);
          if (settle_q == SETTLE_LAST) begin
            state_d = RELEASE;
            rst_d   = rst_q << 1;
            gap_d   = '0;
          end
        end
      end
      RELEASE: begin
        // Shifting a zero into bit 0 keeps release strictly ascending.
        if (rst_q == '0) begin
          state_d = RUN;
          ready_d = 1'b1;
        end else if (gap_q == GAP_LAST) begin
          rst_d = rst_q << 1;
          gap_d = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase

    // Loss filter overrides release progress on the edge it fires.
    if (state_q == RELEASE || state_q == RUN) begin
      if (pll_locked) begin
        filt_d = '0;
      end else if (filt_q == FILT_LAST) begin
        loss_event = 1'b1;
        filt_d     = '0;
        state_d    = WAIT_LOCK;
        rst_d      = '1;
        ready_d    = 1'b0;
        lost_d     = 1'b1;
      end else begin
        filt_d = filt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (rst_in) begin
      state_q  <= WAIT_LOCK;
      settle_q <= '0;
      gap_q    <= '0;
      filt_q   <= '0;
      rst_q    <= '1;
      ready_q  <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      gap_q    <= gap_d;
      filt_q   <= filt_d;
      rst_q    <= rst_d;
      ready_q  <= ready_d;
      lost_q   <= lost_d;
    end
  end

  assign rst_out   = rst_q;
  assign ready     = ready_q;
  assign lock_lost = lost_q;

`ifdef PLL_RST_SEQ_LOSS_COUNT_EN
  logic [7:0] count_q, count_d, count_base;

  // Clear is applied first so a coincident loss leaves the count at one.
  always_comb begin
    count_base = clear_in ? 8'd0 : count_q;
    count_d    = count_base;
    if (loss_event && count_base != 8'hFF) begin
      count_d = count_base + 8'd1;
    end
  end

  always_ff @(posedge clock_in) begin
    if (rst_in) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign loss_count = count_q;
`else
  logic unused_loss_event;
  assign unused_loss_event = loss_event;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomised and directed bench for pll_reset_sequencer against a timeline-based model.
// Covers PLL_RST_SEQ_LOSS_COUNT_EN builds when the macro is defined.
module tb_pll_reset_sequencer;
  localparam int SETTLE = 8;
  localparam int STAGES = 3;
  localparam int GAP    = 4;
  localparam int FILTER = 3;
  localparam int ONES   = (1 << STAGES) - 1;

  logic              clock_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              pll_locked = 1'b0;
  logic              clear_in = 1'b0;
  logic [STAGES-1:0] rst_out;
  logic              ready;
  logic              lock_lost;
`ifdef PLL_RST_SEQ_LOSS_COUNT_EN
  logic [7:0]        loss_count;
`endif

  int total = 0;
  int bad   = 0;

  // Model: t = edges since E0 (-1 while waiting for lock), low = consecutive lows once released.
  int m_t    = -1;
  int m_low  = 0;
  int m_lost = 0;
  int m_cnt  = 0;

  pll_reset_sequencer #(
    .SETTLE_CYCLES(SETTLE),
    .STAGES(STAGES),
    .STAGE_GAP(GAP),
    .LOSS_FILTER(FILTER)
  ) dut (
    .clock_in(clock_in),
    .rst_in(rst_in),
    .pll_locked(pll_locked),
    .clear_in(clear_in),
    .rst_out(rst_out),
    .ready(ready),
`ifdef PLL_RST_SEQ_LOSS_COUNT_EN
    .lock_lost(lock_lost),
    .loss_count(loss_count)
`else
    .lock_lost(lock_lost)
`endif
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0d)", tag, got, exp, m_t);
    end
  endtask

  function automatic int exp_rst(input int t);
    int n;
    if (t < SETTLE) return ONES;
    n = (t - SETTLE) / GAP + 1;
    if (n > STAGES) n = STAGES;
    return ONES & ~((1 << n) - 1);
  endfunction

  function automatic int exp_ready(input int t);
    return (t >= SETTLE + (STAGES - 1) * GAP + 1) ? 1 : 0;
  endfunction

  task automatic model_edge(input bit r, input bit lk, input bit clr);
    bit loss;
    loss = 1'b0;
    if (r) begin
      m_t = -1; m_low = 0; m_lost = 0; m_cnt = 0;
    end else begin
      if (m_t < 0) begin
        if (lk) m_t = 0;
      end else if (m_t < SETTLE) begin
        if (lk) m_t++;
        else m_t = -1;
      end else begin
        if (lk) m_low = 0;
        else m_low++;
        if (m_low == FILTER) begin
          loss = 1'b1; m_t = -1; m_low = 0;
        end else begin
          m_t++;
        end
      end
      if (clr) begin
        m_lost = 0; m_cnt = 0;
      end
      if (loss) begin
        m_lost = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  endtask

  task automatic step(input string tag, input bit r, input bit lk, input bit clr);
    rst_in = r; pll_locked = lk; clear_in = clr;
    @(posedge clock_in);
    model_edge(r, lk, clr);
    #1;
    check({tag, ".rst_out"}, 32'(rst_out), 32'(exp_rst(m_t)));
    check({tag, ".ready"}, 32'(ready), 32'(exp_ready(m_t)));
    check({tag, ".lock_lost"}, 32'(lock_lost), 32'(m_lost));
`ifdef PLL_RST_SEQ_LOSS_COUNT_EN
    check({tag, ".loss_count"}, 32'(loss_count), 32'(m_cnt));
`endif
  endtask

  initial begin
    int hi, lo;

    step("reset", 1, 1, 0);
    step("reset", 1, 0, 0);
    check("reset_rst_out", 32'(rst_out), 32'(ONES));
    check("reset_ready", 32'(ready), 32'd0);
    $display("txn reset rst_out=%b ready=%0d", rst_out, ready);

    // Clean lock: E0 is the first step, edge E0+k is the (k+1)-th step.
    for (int k = 0; k <= 20; k++) begin
      step("clean", 0, 1, 0);
      if (k == 7)  check("clean_e7",  32'(rst_out), 32'b111);
      if (k == 8)  check("clean_e8",  32'(rst_out), 32'b110);
      if (k == 12) check("clean_e12", 32'(rst_out), 32'b100);
      if (k == 16) check("clean_e16", 32'(rst_out), 32'b000);
      if (k == 16) check("clean_rdy16", 32'(ready), 32'd0);
      if (k == 17) check("clean_rdy17", 32'(ready), 32'd1);
    end
    $display("txn clean_lock rst_out=%b ready=%0d lock_lost=%0d", rst_out, ready, lock_lost);

    // Settle abort: one low sample at E0+5.
    step("abort_rst", 1, 0, 0);
    for (int k = 0; k <= 4; k++) step("abort_pre", 0, 1, 0);
    step("abort_drop", 0, 0, 0);
    for (int k = 0; k <= 20; k++) begin
      step("abort_post", 0, 1, 0);
      if (k == 7) check("abort_e7", 32'(rst_out), 32'b111);
      if (k == 8) check("abort_e8", 32'(rst_out), 32'b110);
    end
    check("abort_lost", 32'(lock_lost), 32'd0);
    $display("txn settle_abort rst_out=%b lock_lost=%0d", rst_out, lock_lost);

    // Glitch rejection then real loss in RUN.
    step("glitch", 0, 0, 0);
    step("glitch", 0, 0, 0);
    check("glitch_ready", 32'(ready), 32'd1);
    step("glitch_end", 0, 1, 0);
    step("loss", 0, 0, 0);
    step("loss", 0, 0, 0);
    step("loss", 0, 0, 0);
    check("loss_rst_out", 32'(rst_out), 32'(ONES));
    check("loss_lost", 32'(lock_lost), 32'd1);
    $display("txn lock_loss rst_out=%b ready=%0d lock_lost=%0d", rst_out, ready, lock_lost);
    for (int k = 0; k <= 20; k++) step("relock", 0, 1, 0);
    $display("txn relock rst_out=%b ready=%0d", rst_out, ready);

    // Clear coinciding with a second loss, then a lone clear.
    step("coll", 0, 0, 0);
    step("coll", 0, 0, 0);
    step("coll_hit", 0, 0, 1);
    check("coll_lost", 32'(lock_lost), 32'd1);
    step("lone_clear", 0, 0, 1);
    check("clear_lost", 32'(lock_lost), 32'd0);
    $display("txn clear_collision lock_lost=%0d", lock_lost);

    // Reset in the middle of release at E0+13.
    for (int k = 0; k <= 13; k++) step("midrel", 0, 1, 0);
    step("midrel_rst", 1, 1, 0);
    check("midrel_rst_out", 32'(rst_out), 32'(ONES));
    check("midrel_ready", 32'(ready), 32'd0);
    $display("txn reset_mid_release rst_out=%b ready=%0d", rst_out, ready);

    // Random bursts of high and low lock with occasional clears and resets.
    for (int b = 0; b < 150; b++) begin
      if ($urandom_range(0, 19) == 0) begin
        step("rnd_rst", 1, $urandom_range(0, 1), 0);
        $display("txn rnd %0d reset", b);
      end else begin
        hi = $urandom_range(1, 25);
        lo = $urandom_range(1, 4);
        for (int k = 0; k < hi; k++) step("rnd_hi", 0, 1, $urandom_range(0, 7) == 0);
        for (int k = 0; k < lo; k++) step("rnd_lo", 0, 0, $urandom_range(0, 7) == 0);
        $display("txn rnd %0d hi=%0d lo=%0d rst_out=%b ready=%0d lost=%0d", b, hi, lo, rst_out, ready, lock_lost);
      end
    end

`ifdef PLL_RST_SEQ_LOSS_COUNT_EN
    step("sat_rst", 1, 0, 0);
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k <= SETTLE; k++) step("sat_hi", 0, 1, 0);
      for (int k = 0; k < FILTER; k++) step("sat_lo", 0, 0, 0);
    end
    check("sat_count", 32'(loss_count), 32'd255);
    $display("txn saturation loss_count=%0d", loss_count);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
